dig_scan_driver: RTL and testbench
==================================

Name: dig_scan_driver

Overview:
- Memory-mapped 8-digit, 7-segment display peripheral. It sits directly downstream of the bus bridge and consumes the bridge's digit-write strobe and 32-bit write data.
- Latches one 32-bit word per write and shows it as 8 hex digits. Digit 0 is value[3:0] and sits rightmost; digit 7 is value[31:28].
- Drives the display by time-multiplexing the digits, one at a time.
- Write-only; there is no read-back path.

Parameters:
- SCAN_CYCLES, 20000: clock cycles each digit stays lit before the scan advances. Legal range is 1 or more; the bench uses 4.

Ports:
- clk  in  1  system clock, shared with the CPU.
- rst  in  1  reset, synchronous and active-low; acts only on the rising edge of clk.
- we_dig  in  1  write strobe; this is bit 3 of the bridge's enable_sel (digit access qualified by store).
- wdata_dig  in  32  write data from the bridge. Only meaningful while we_dig=1; otherwise it carries filler (32'hDEAD_6666).
- dig_en  out  8  digit anodes, active-low, one-hot-low; bit i selects digit i.
- seg  out  8  segments, active-low, ordered {CA,CB,CC,CD,CE,CF,CG,DP}.

Behaviour:
- All state is updated on the rising edge of clk only.
- Reset (rst=0 at an edge) sets:
  - value_q = 0
  - scan_cnt = 0
  - idx = 0
  - dig_en = 8'hFF (all digits off)
  - seg = 8'hFF (all segments off)
- Reset asserted mid-scan or mid-write takes priority over everything at that edge. The write is discarded.
- Write path:
  - If we_dig=1 at an edge, value_q <= wdata_dig.
  - If we_dig=0, value_q holds, whatever wdata_dig carries.
  - value_q changes only on writes; there are no partial writes.
- Scan counter:
  - scan_cnt counts 0 .. SCAN_CYCLES-1.
  - At terminal count, scan_cnt <= 0 and idx <= idx+1, wrapping 7 to 0.
  - If SCAN_CYCLES=1, idx advances every cycle.
  - scan_cnt width is clog2(SCAN_CYCLES), minimum 1 bit.
- Output register:
  - Every non-reset edge: dig_en <= ~(8'b1 << idx) and seg <= decode(value_q[4*idx +: 4]). Both use the pre-edge idx and value_q.
  - DP is always 1 (off).
- Latency:
  - After reset release, the first edge drives digit 0 (dig_en=8'hFE).
  - A write at edge k appears on seg at edge k+1, provided the addressed digit is currently selected.
  - Outputs lag idx by exactly one cycle. dig_en and seg always change at the same edge, so no ghosting is introduced by skew.
- Simultaneous events: a write and a scan advance at the same edge both take effect. At the following edge the output shows the new value on the new digit.
- Decode table (seg, active-low):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71
- Decode is a full case; no X is ever driven for a defined input.

Decomposition:
- The following go in defines.vh, next to the PERI_ADDR_* macros:
  - SEG_* codes for the 16 hex glyphs
  - SEG_OFF = 8'hFF
  - DIG_SCAN_CYCLES default
- Sub-module seg7_decode is combinational: 4-bit nibble in, 8-bit active-low seg out. It is instantiated once, fed by the idx mux.
- Everything else (counter, idx, latch, output register) lives in dig_scan_driver.

Test Plan (SCAN_CYCLES=4):
- Reset: hold rst=0 for 3 cycles, then release. During reset dig_en=FF and seg=FF. At the first edge after release, dig_en=FE and seg=03 (digit 0 shows "0").
- Write and scan: write 32'h1234_5678 in the cycle after reset release. Digit 0 shows seg=01 ("8"). After 4 cycles, dig_en=FD and seg=1F ("7"). Stepping through digits 0..7 gives 01,1F,41,49,99,0D,25,9F. After digit 7 the scan wraps back to FE.
- Filler immunity: drive we_dig=0 with wdata_dig=32'hDEAD_6666 for 40 cycles. value_q is unchanged and the scan pattern is identical to the previous scenario.
- Write at terminal count: write 32'hFFFF_FFFF exactly at the edge where idx advances 2 to 3. The next edge gives dig_en=F7 and seg=71.
- Mid-scan reset: assert rst=0 for 1 cycle while idx=5 and value=32'hABCD_EF01. Next state is dig_en=FF, seg=FF, value_q=0. After release the first edge gives dig_en=FE and seg=03.
- All glyphs: write 32'h89AB_CDEF, then 32'h0123_4567. Each digit's seg matches the decode table for all 16 nibbles, and DP stays 1 throughout.

Source files
------------

// File: rtl/dig_scan_driver_pkg.sv
// Shared constants for the 8-digit seven-segment scan driver: glyph codes and scan defaults.
package dig_scan_driver_pkg;

    localparam int unsigned DIG_SCAN_CYCLES = 20000;
    localparam int unsigned NUM_DIGITS      = 8;
    localparam int unsigned IDX_W           = 3;
    localparam int unsigned SEG_W           = 8;
    localparam int unsigned DATA_W          = 32;

    // Active-low segment codes, bit order {CA,CB,CC,CD,CE,CF,CG,DP}; DP always off.
    localparam logic [SEG_W-1:0] SEG_0   = 8'h03;
    localparam logic [SEG_W-1:0] SEG_1   = 8'h9F;
    localparam logic [SEG_W-1:0] SEG_2   = 8'h25;
    localparam logic [SEG_W-1:0] SEG_3   = 8'h0D;
    localparam logic [SEG_W-1:0] SEG_4   = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5   = 8'h49;
    localparam logic [SEG_W-1:0] SEG_6   = 8'h41;
    localparam logic [SEG_W-1:0] SEG_7   = 8'h1F;
    localparam logic [SEG_W-1:0] SEG_8   = 8'h01;
    localparam logic [SEG_W-1:0] SEG_9   = 8'h09;
    localparam logic [SEG_W-1:0] SEG_A   = 8'h11;
    localparam logic [SEG_W-1:0] SEG_B   = 8'hC1;
    localparam logic [SEG_W-1:0] SEG_C   = 8'h63;
    localparam logic [SEG_W-1:0] SEG_D   = 8'h85;
    localparam logic [SEG_W-1:0] SEG_E   = 8'h61;
    localparam logic [SEG_W-1:0] SEG_F   = 8'h71;
    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/dig_scan_driver_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_decode
    import dig_scan_driver_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/dig_scan_driver.sv
// Write-only 8-digit hex display: latches a 32-bit word and time-multiplexes it across the digits.
module dig_scan_driver
    import dig_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES = DIG_SCAN_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_dig,
    input  logic [DATA_W-1:0]   wdata_dig,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [SEG_W-1:0]    seg
);

    localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);

    logic [DATA_W-1:0]     value_q,  value_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic [SEG_W-1:0]      seg_q;
    logic [3:0]            nibble_c;
    logic [SEG_W-1:0]      seg_c;

    seg7_decode u_decode (
        .nibble_i (nibble_c),
        .seg_o    (seg_c)
    );

    // Next-state: write latch, dwell counter, digit index and anode pattern from pre-edge state.
    always_comb begin
        value_d  = value_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        nibble_c = value_q[{idx_q, 2'b00} +: 4];
        dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
        if (we_dig) begin
            value_d = wdata_dig;
        end
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            dig_en_q <= '1;
            seg_q    <= SEG_OFF;
        end else begin
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_c;
        end
    end

    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_dig_scan_driver.sv
// Randomised scoreboard bench for dig_scan_driver with SCAN_CYCLES=4.
module tb_dig_scan_driver;

    localparam int unsigned SC = 4;

    logic        clk;
    logic        rst;
    logic        we_dig;
    logic [31:0] wdata_dig;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    typedef struct packed {
        logic [7:0] dig_en;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: latched word and cycles elapsed since reset release.
    logic [31:0] m_value;
    int          m_t;
    logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    dig_scan_driver #(.SCAN_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_dig    (we_dig),
        .wdata_dig (wdata_dig),
        .dig_en    (dig_en),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur_digit();
        return (m_t / SC) % 8;
    endfunction

    // Drive one cycle of inputs and push the output expected after the coming edge.
    task automatic step(input logic r, input logic we, input logic [31:0] d);
        exp_t e;
        int   k;
        @(negedge clk);
        rst       = r;
        we_dig    = we;
        wdata_dig = d;
        if (!r) begin
            e.dig_en = 8'hFF;
            e.seg    = 8'hFF;
            m_value  = 32'h0;
            m_t      = 0;
        end else begin
            k        = cur_digit();
            e.dig_en = 8'hFF ^ (8'h01 << k);
            e.seg    = seg_tab[(m_value >> (4 * k)) & 32'hF];
            if (we) m_value = d;
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'hDEAD_6666);
    endtask

    // Monitor: one registered output per cycle, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (dig_en !== e.dig_en) begin
                    bad++;
                    $display("FAIL dig_en t=%0t got=%h want=%h", $time, dig_en, e.dig_en);
                end
                total++;
                if (seg !== e.seg) begin
                    bad++;
                    $display("FAIL seg t=%0t got=%h want=%h", $time, seg, e.seg);
                end
                total++;
                if (seg[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL dp t=%0t got=%b want=1", $time, seg[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; we_dig = 1'b0; wdata_dig = 32'hDEAD_6666;
        m_value = 32'h0; m_t = 0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hDEAD_6666);
        step(1'b1, 1'b1, 32'h1234_5678);
        idle(40);

        // Filler on the bus for a full scan and more must not disturb the latch.
        idle(40);

        // Write landing exactly on the 2->3 index advance.
        while (m_t % (8 * SC) != 3 * SC - 1) idle(1);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        idle(6);

        // Reset in the middle of digit 5.
        step(1'b1, 1'b1, 32'hABCD_EF01);
        while (cur_digit() != 5) idle(1);
        idle(1);
        step(1'b0, 1'b0, 32'hDEAD_6666);
        idle(34);

        step(1'b1, 1'b1, 32'h89AB_CDEF);
        idle(34);
        step(1'b1, 1'b1, 32'h0123_4567);
        idle(34);

        // SCAN_CYCLES=1 is not covered here; random writes and resets at arbitrary phases.
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic we;
            r  = ($urandom_range(0, 49) != 0);
            we = ($urandom_range(0, 9) == 0);
            step(r, we, we ? 32'($urandom) : 32'hDEAD_6666);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
